// File: rtl/kernel_group_scheduler.sv
// kernel_group_scheduler
//   Time-multiplexes each input pixel over G = NumberOfK/ProcessingElements
//   kernel groups. It drives the PE group select and builds a per-kernel valid
//   mask, delayed by PeLatency advancing cycles so that it lines up with the PE
//   results going into mem_module. It flags the last mask of every
//   ImageWidth x ImageWidth image.
//
// Ports
//   clk, res_n    clock, synchronous active-low reset
//   px_valid      upstream pixel present
//   px_ready      pixel consumed (final group issued this cycle)
//   mem_ready     downstream can accept; 0 stalls the whole block
//   pipe_en       PE pipeline advance enable (== mem_ready)
//   issue_valid   PEs compute group grp_sel this cycle
//   grp_sel       active kernel group
//   kernel_valid  aligned per-kernel valid mask
//   image_done    one-cycle pulse with the final kernel_valid of an image
//   stall_cycles  (SCHED_STALL_CNT_EN only) saturating stall/bubble counter
//
// Optional feature macro: SCHED_STALL_CNT_EN

module kernel_group_scheduler #(
  parameter int NumberOfK          = 4,
  parameter int ProcessingElements = 2,
  parameter int ImageWidth         = 2,
  parameter int PeLatency          = 1
) (
  input  logic clk,
  input  logic res_n,
  input  logic px_valid,
  output logic px_ready,
  input  logic mem_ready,
  output logic pipe_en,
  output logic issue_valid,
  output logic [((NumberOfK/ProcessingElements) > 1 ?
                 $clog2(NumberOfK/ProcessingElements) : 1)-1:0] grp_sel,
  output logic [NumberOfK-1:0] kernel_valid,
`ifdef SCHED_STALL_CNT_EN
  output logic [15:0] stall_cycles,
`endif
  output logic image_done
);

  localparam int G    = NumberOfK / ProcessingElements;
  localparam int GW   = (G > 1) ? $clog2(G) : 1;
  localparam int NPIX = ImageWidth * ImageWidth;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int DW   = (PeLatency > 1) ? $clog2(PeLatency) : 1;

  if ((NumberOfK % ProcessingElements) != 0 || NumberOfK < ProcessingElements) begin : g_bad_k
    $error("NumberOfK must be a positive multiple of ProcessingElements");
  end
  if (PeLatency < 1) begin : g_bad_lat
    $error("PeLatency must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                             state_q, state_d;
  logic [GW-1:0]                      g_q, g_d;
  logic [PW-1:0]                      p_q, p_d;
  logic [DW-1:0]                      dcnt_q, dcnt_d;
  logic [PeLatency-1:0][NumberOfK-1:0] dl_q, dl_d;
  logic [NumberOfK-1:0]               mask;
  logic                               issue, done;

  // next-state / outputs
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    p_d      = p_q;
    dcnt_d   = dcnt_q;
    issue    = 1'b0;
    done     = 1'b0;
    px_ready = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (res_n && px_valid && mem_ready) begin
          issue   = 1'b1;
          state_d = RUN;
          if (g_q == GW'(G-1)) begin
            px_ready = 1'b1;
            g_d      = '0;
            if (p_q == PW'(NPIX-1)) begin
              p_d     = '0;
              dcnt_d  = '0;
              state_d = DRAIN;
            end else begin
              p_d = p_q + 1'b1;
            end
          end else begin
            g_d = g_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // the last issued mask reaches the output on the PeLatency-th advance
        if (res_n && mem_ready) begin
          if (dcnt_q == DW'(PeLatency-1)) begin
            done    = 1'b1;
            dcnt_d  = '0;
            state_d = IDLE;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // mask for the group being issued; zero on bubbles, stalls and drain
  always_comb begin
    mask = '0;
    for (int k = 0; k < NumberOfK; k++)
      mask[k] = issue && ((k / ProcessingElements) == int'(g_q));
  end

  // delay line advances only while downstream accepts
  always_comb begin
    dl_d = dl_q;
    if (mem_ready) begin
      dl_d[0] = mask;
      for (int i = 1; i < PeLatency; i++) dl_d[i] = dl_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      p_q     <= '0;
      dcnt_q  <= '0;
      dl_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      dcnt_q  <= dcnt_d;
      dl_q    <= dl_d;
    end
  end

  assign pipe_en      = mem_ready;
  assign issue_valid  = issue;
  assign grp_sel      = g_q;
  assign kernel_valid = (res_n && mem_ready) ? dl_q[PeLatency-1] : '0;
  assign image_done   = done;

`ifdef SCHED_STALL_CNT_EN
  logic [15:0] sc_q, sc_d;
  logic        sc_inc, sc_clr;

  assign sc_inc = ((state_q != IDLE) && !mem_ready) || ((state_q == RUN) && !px_valid);
  assign sc_clr = issue && (g_q == '0) && (p_q == '0);

  always_comb begin
    sc_d = sc_q;
    if (sc_clr)                       sc_d = '0;
    else if (sc_inc && sc_q != 16'hFFFF) sc_d = sc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!res_n) sc_q <= '0;
    else        sc_q <= sc_d;
  end

  assign stall_cycles = sc_q;
`endif

endmodule

// File: tb/tb_kernel_group_scheduler.sv
module tb_kernel_group_scheduler;
  localparam int K = 4, PE = 2, IW = 2, LAT = 1;
  localparam int G = K / PE, TOT = G * IW * IW;
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  logic clk = 0, res_n = 0, px_valid = 0, mem_ready = 0;
  logic px_ready, pipe_en, issue_valid, image_done;
  logic [GW-1:0] grp_sel;
  logic [K-1:0] kernel_valid;
`ifdef SCHED_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  kernel_group_scheduler #(.NumberOfK(K), .ProcessingElements(PE), .ImageWidth(IW), .PeLatency(LAT)) dut (
    .clk(clk), .res_n(res_n), .px_valid(px_valid), .px_ready(px_ready), .mem_ready(mem_ready),
    .pipe_en(pipe_en), .issue_valid(issue_valid), .grp_sel(grp_sel), .kernel_valid(kernel_valid),
`ifdef SCHED_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .image_done(image_done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // n counts issues within the current image; draining covers the tail
  // after the last issue until the final mask leaves the delay line.
  int n = 0, drem = 0, sc = 0;
  bit draining = 0;
  logic [K-1:0] dq[$];
  bit m_iv, m_rdy, m_done;
  int m_grp;
  logic [K-1:0] m_kv;

  function automatic logic [K-1:0] grp_mask(int gg);
    logic [K-1:0] m = '0;
    for (int k = 0; k < K; k++) m[k] = (k / PE == gg);
    return m;
  endfunction

  task automatic model_reset();
    n = 0; draining = 0; drem = 0; sc = 0;
    dq.delete();
    repeat (LAT) dq.push_back('0);
  endtask

  task automatic model_eval();
    m_iv   = res_n && !draining && px_valid && mem_ready;
    m_grp  = n % G;
    m_rdy  = m_iv && (m_grp == G - 1);
    m_kv   = (res_n && mem_ready) ? dq[0] : '0;
    m_done = res_n && draining && mem_ready && (drem == 1);
  endtask

  task automatic model_update();
    bit running;
    if (!res_n) begin model_reset(); return; end
    running = !draining && n > 0;
    if (m_iv && n == 0) sc = 0;
    else if (((running || draining) && !mem_ready) || (running && !px_valid))
      sc = (sc < 65535) ? sc + 1 : sc;
    if (mem_ready) begin
      void'(dq.pop_front());
      dq.push_back(m_iv ? grp_mask(m_grp) : '0);
    end
    if (m_iv) begin
      n++;
      if (n == TOT) begin draining = 1; drem = LAT; end
    end else if (draining && mem_ready) begin
      drem--;
      if (drem == 0) begin draining = 0; n = 0; end
    end
  endtask

  // ---------------- cycle driver ----------------
  int nkv, nis, ndone;
  bit mcheck = 1;

  task automatic cyc(input logic rn, input logic pv, input logic mr);
    @(negedge clk);
    res_n = rn; px_valid = pv; mem_ready = mr;
    #1;
    model_eval();
    if (mcheck) begin
      chk("issue_valid", 32'(issue_valid), 32'(m_iv));
      chk("px_ready", 32'(px_ready), 32'(m_rdy));
      chk("grp_sel", 32'(grp_sel), 32'(m_grp));
      chk("kernel_valid", 32'(kernel_valid), 32'(m_kv));
      chk("image_done", 32'(image_done), 32'(m_done));
      chk("pipe_en", 32'(pipe_en), 32'(mem_ready));
`ifdef SCHED_STALL_CNT_EN
      chk("stall_cycles", 32'(stall_cycles), 32'(sc));
`endif
    end
    nkv   += (kernel_valid != '0);
    nis   += issue_valid;
    ndone += image_done;
    model_update();
  endtask

  task automatic clr_cnt(); nkv = 0; nis = 0; ndone = 0; endtask

  task automatic run_to_done(string name);
    int budget = 40;
    while (ndone == 0 && budget > 0) begin cyc(1, 1, 1); budget--; end
    chk({name, "_done_seen"}, 32'(ndone), 32'd1);
  endtask

  typedef struct {
    logic rn, pv, mr;
    logic iv, rdy;
    int   grp;
    logic [K-1:0] kv;
    logic done;
  } vec_t;

  vec_t tbl[12];

  initial begin
    model_reset();
    // unchecked settle: registers take their reset values on this edge
    mcheck = 0;
    cyc(0, 1, 1);
    mcheck = 1;

    // ---- table: reset then one back-to-back image ----
    tbl[0]  = '{0, 1, 1, 0, 0, 0, 4'b0000, 0};
    tbl[1]  = '{1, 1, 1, 1, 0, 0, 4'b0000, 0};
    tbl[2]  = '{1, 1, 1, 1, 1, 1, 4'b0011, 0};
    tbl[3]  = '{1, 1, 1, 1, 0, 0, 4'b1100, 0};
    tbl[4]  = '{1, 1, 1, 1, 1, 1, 4'b0011, 0};
    tbl[5]  = '{1, 1, 1, 1, 0, 0, 4'b1100, 0};
    tbl[6]  = '{1, 1, 1, 1, 1, 1, 4'b0011, 0};
    tbl[7]  = '{1, 1, 1, 1, 0, 0, 4'b1100, 0};
    tbl[8]  = '{1, 1, 1, 1, 1, 1, 4'b0011, 0};
    tbl[9]  = '{1, 0, 1, 0, 0, 0, 4'b1100, 1};
    tbl[10] = '{1, 0, 1, 0, 0, 0, 4'b0000, 0};
    tbl[11] = '{1, 1, 1, 1, 0, 0, 4'b0000, 0};
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].rn, tbl[i].pv, tbl[i].mr);
      chk($sformatf("tbl%0d_iv", i), 32'(issue_valid), 32'(tbl[i].iv));
      chk($sformatf("tbl%0d_rdy", i), 32'(px_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_grp", i), 32'(grp_sel), 32'(tbl[i].grp));
      chk($sformatf("tbl%0d_kv", i), 32'(kernel_valid), 32'(tbl[i].kv));
      chk($sformatf("tbl%0d_done", i), 32'(image_done), 32'(tbl[i].done));
    end

    // ---- upstream bubble after group 0 of pixel 1 ----
    cyc(0, 0, 1); clr_cnt();
    repeat (3) cyc(1, 1, 1);
    repeat (2) begin
      cyc(1, 0, 1);
      chk("bubble_grp_hold", 32'(grp_sel), 32'd1);
      chk("bubble_no_ready", 32'(px_ready), 32'd0);
    end
    run_to_done("bubble");
    chk("bubble_masks", 32'(nkv), 32'd8);
    chk("bubble_issues", 32'(nis), 32'd8);

    // ---- downstream stall when 4'b1100 is due ----
    cyc(0, 0, 1); clr_cnt();
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    chk("stall_pre_kv", 32'(kernel_valid), 32'b0011);
    repeat (3) begin
      cyc(1, 1, 0);
      chk("stall_kv_zero", 32'(kernel_valid), 32'd0);
      chk("stall_no_issue", 32'(issue_valid), 32'd0);
    end
    cyc(1, 1, 1);
    chk("stall_kv_resume", 32'(kernel_valid), 32'b1100);
    run_to_done("stall");
    chk("stall_masks", 32'(nkv), 32'd8);
    chk("stall_issues", 32'(nis), 32'd8);

    // ---- reset mid-image after 5 issues ----
    cyc(0, 0, 1); clr_cnt();
    repeat (5) cyc(1, 1, 1);
    cyc(0, 1, 1);
    clr_cnt();
    cyc(1, 1, 1);
    chk("midrst_grp0", 32'(grp_sel), 32'd0);
    chk("midrst_kv0", 32'(kernel_valid), 32'd0);
    run_to_done("midrst");
    chk("midrst_issues", 32'(nis), 32'd8);
    chk("midrst_masks", 32'(nkv), 32'd8);

    // ---- randomized traffic against the model ----
    cyc(0, 0, 1);
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
